// File: rtl/mod_alu_seq.sv
// mod_alu_seq
// Command-level sequencer in front of a single-cycle datapath ALU.
// A command (opcode + two operands) is accepted over a valid/ready channel,
// executed on the external ALU, and the registered result and flags are
// returned over a valid/ready response channel. Opcode 10 (MUL) is built
// here as a shift-and-add loop that reuses the ALU adder, one partial
// product per cycle. This lets the control unit treat every operation as a
// single transaction.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   cmd_valid/ready  : command handshake; cmd_op, cmd_a, cmd_b carry the command
//   rsp_valid/ready  : response handshake; rsp_result plus flags
//                      rsp_cout (ADD carry / MUL overflow), rsp_neg (SUB a<b),
//                      rsp_zero (result == 0), rsp_err (illegal opcode)
//   alu_a/b/sel      : operands and select driven to the ALU
//   alu_result/cout/neg : ALU result and flags fed back
module mod_alu_seq #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [width-1:0] cmd_a,
  input  logic [width-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_neg,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [width-1:0] alu_a,
  output logic [width-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [width-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_neg
);

  localparam int CW = $clog2(width + 1);

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_LAST_ALU = 4'd9;
  localparam logic [3:0] OP_MUL     = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic             cmd_ready_r;
  logic             rsp_valid_r;
  logic [width-1:0] rsp_result_r;
  logic             rsp_cout_r;
  logic             rsp_neg_r;
  logic             rsp_zero_r;
  logic             rsp_err_r;
  // During MUL, alu_a_r doubles as the accumulator and alu_b_r as the
  // shifted multiplicand, so the ALU sees them directly from registers.
  logic [width-1:0] alu_a_r;
  logic [width-1:0] alu_b_r;
  logic [3:0]       alu_sel_r;
  logic [width-1:0] mplier_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt_r;

  logic [width-1:0] mul_acc_s;
  logic             mul_ovf_s;

  function automatic logic is_zero(input logic [width-1:0] v);
    return (v == {width{1'b0}});
  endfunction

  // Next accumulator and overflow for one shift-and-add step. Overflow also
  // catches a multiplicand bit about to be shifted out while multiplier bits
  // that would still add it remain.
  always_comb begin
    mul_acc_s = alu_a_r;
    mul_ovf_s = ovf_r | (alu_b_r[width-1] & (|mplier_r[width-1:1]));
    if (mplier_r[0]) begin
      mul_acc_s = alu_result;
      mul_ovf_s = mul_ovf_s | alu_cout;
    end else begin
      mul_acc_s = alu_a_r;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cmd_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {width{1'b0}};
      rsp_cout_r   <= 1'b0;
      rsp_neg_r    <= 1'b0;
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
      alu_a_r      <= {width{1'b0}};
      alu_b_r      <= {width{1'b0}};
      alu_sel_r    <= 4'd0;
      mplier_r     <= {width{1'b0}};
      ovf_r        <= 1'b0;
      cnt_r        <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            if (cmd_op <= OP_LAST_ALU) begin
              state_r   <= ST_EXEC;
              alu_a_r   <= cmd_a;
              alu_b_r   <= cmd_b;
              alu_sel_r <= cmd_op;
            end else if (cmd_op == OP_MUL) begin
              state_r   <= ST_MUL;
              alu_a_r   <= {width{1'b0}};
              alu_b_r   <= cmd_a;
              alu_sel_r <= OP_ADD;
              mplier_r  <= cmd_b;
              ovf_r     <= 1'b0;
              cnt_r     <= {CW{1'b0}};
            end else begin
              // Illegal opcode: answer immediately with err and a zero result.
              state_r      <= ST_DONE;
              rsp_valid_r  <= 1'b1;
              rsp_result_r <= {width{1'b0}};
              rsp_cout_r   <= 1'b0;
              rsp_neg_r    <= 1'b0;
              rsp_zero_r   <= 1'b1;
              rsp_err_r    <= 1'b1;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          state_r      <= ST_DONE;
          rsp_valid_r  <= 1'b1;
          rsp_result_r <= alu_result;
          rsp_cout_r   <= (alu_sel_r == OP_ADD) & alu_cout;
          rsp_neg_r    <= (alu_sel_r == OP_SUB) & alu_neg;
          rsp_zero_r   <= is_zero(alu_result);
          rsp_err_r    <= 1'b0;
          alu_a_r      <= {width{1'b0}};
          alu_b_r      <= {width{1'b0}};
          alu_sel_r    <= 4'd0;
        end
        ST_MUL: begin
          ovf_r    <= mul_ovf_s;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CW'(width - 1)) begin
            state_r      <= ST_DONE;
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= mul_acc_s;
            rsp_cout_r   <= mul_ovf_s;
            rsp_neg_r    <= 1'b0;
            rsp_zero_r   <= is_zero(mul_acc_s);
            rsp_err_r    <= 1'b0;
            alu_a_r      <= {width{1'b0}};
            alu_b_r      <= {width{1'b0}};
            alu_sel_r    <= 4'd0;
          end else begin
            alu_a_r <= mul_acc_s;
            alu_b_r <= alu_b_r << 1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_cout   = rsp_cout_r;
  assign rsp_neg    = rsp_neg_r;
  assign rsp_zero   = rsp_zero_r;
  assign rsp_err    = rsp_err_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_sel    = alu_sel_r;

endmodule

// File: tb/tb_mod_alu_seq.sv
// Testbench for mod_alu_seq: behavioural ALU model on the alu_* port,
// directed command sequence, scoreboard queue of expected responses.
module tb_mod_alu_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_neg;
  logic         rsp_zero;
  logic         rsp_err;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         alu_neg;

  typedef struct {
    logic [W-1:0] result;
    logic         cout;
    logic         neg;
    logic         zero;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mod_alu_seq #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_neg(rsp_neg),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_neg(alu_neg)
  );

  always #5 clk = ~clk;

  // Behavioural model of the datapath ALU.
  always_comb begin
    logic [W:0] sum;
    sum        = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = '0;
    alu_cout   = 1'b0;
    alu_neg    = 1'b0;
    case (alu_sel)
      4'd0: begin alu_result = sum[W-1:0]; alu_cout = sum[W]; end
      4'd1: begin
        alu_neg    = (alu_a < alu_b);
        alu_result = (alu_a < alu_b) ? (alu_b - alu_a) : (alu_a - alu_b);
      end
      4'd2: alu_result = ~alu_a;
      4'd3: alu_result = alu_a & alu_b;
      4'd4: alu_result = alu_a | alu_b;
      4'd5: alu_result = alu_a ^ alu_b;
      4'd6: alu_result = alu_a << alu_b;
      4'd7: alu_result = alu_a << alu_b;
      4'd8: alu_result = $unsigned($signed(alu_a) >>> alu_b);
      4'd9: alu_result = alu_a >> alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one command at the current negedge, push its expectation, and
  // return at the first negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e_res, input logic e_cout, input logic e_neg,
                       input logic e_zero, input logic e_err, input int e_lat);
    exp_t e;
    e.result = e_res; e.cout = e_cout; e.neg = e_neg;
    e.zero = e_zero; e.err = e_err; e.lat = e_lat;
    check("cmd_ready_before_issue", cmd_ready, 1'b1);
    sb_q.push_back(e);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, compare with the scoreboard, optionally
  // hold off rsp_ready for hold cycles while poking cmd_valid, then release.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_result"}, rsp_result, e.result);
    check({tag, "_cout"}, rsp_cout, e.cout);
    check({tag, "_neg"}, rsp_neg, e.neg);
    check({tag, "_zero"}, rsp_zero, e.zero);
    check({tag, "_err"}, rsp_err, e.err);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'd5; cmd_a = 4'h3; cmd_b = 4'h6;
      @(negedge clk);
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_result"}, rsp_result, e.result);
      check({tag, "_hold_cmd_ready"}, cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_after_release"}, rsp_valid, 1'b0);
    check({tag, "_cmd_ready_after_release"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_alu_sel", alu_sel, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b1);

    // ALU ops: response two cycles after accept.
    issue(4'd0, 4'd9, 4'd8, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    collect("add_9_8", 0);
    issue(4'd1, 4'd3, 4'd5, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    collect("sub_3_5", 0);
    issue(4'd1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    collect("sub_5_5", 0);
    issue(4'd5, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    collect("xor_a_5", 0);

    // MUL: response width+1 cycles after accept.
    issue(4'd10, 4'd3, 4'd5, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    collect("mul_3_5", 0);
    issue(4'd10, 4'd5, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    collect("mul_5_4", 0);
    issue(4'd10, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    collect("mul_0_7", 0);

    // Illegal opcode, then a legal one must come back clean.
    issue(4'd13, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    collect("illegal_13", 0);
    issue(4'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    collect("and_after_illegal", 0);

    // Backpressure with a stray command that must be ignored.
    issue(4'd0, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    collect("add_backpressure", 4);
    repeat (3) @(negedge clk);
    check("no_stray_response", rsp_valid, 1'b0);

    // Reset in the second MUL cycle aborts the transaction.
    cmd_op = 4'd10; cmd_a = 4'd3; cmd_b = 4'd5; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mul_c1_alu_a", alu_a, 4'd0);
    check("mul_c1_alu_b", alu_b, 4'd3);
    check("mul_c1_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs",
          {rsp_valid, rsp_result, rsp_cout, rsp_neg, rsp_zero, rsp_err, alu_a, alu_b, alu_sel},
          32'd0);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    issue(4'd0, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    collect("add_after_abort", 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
